// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit: request opcodes, FSM states
// and small opcode classification helpers.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } mdu_state_t;

    function automatic logic is_signed(input mdu_op_t op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    function automatic logic is_div(input mdu_op_t op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    // MULT/MULTU/DIV/DIVU run through the iterative core; MTHI/MTLO do not.
    function automatic logic is_arith(input mdu_op_t op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// One-bit-per-cycle magnitude engine: a 2*WIDTH shift register shared by shift-add
// multiply and restoring divide, with a single add/subtract datapath.
module mdu_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic               div_mode,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic [2*WIDTH-1:0] acc
);

    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH:0]   addend;
    logic [WIDTH+1:0] sum;
    logic             borrow;
    logic [2*WIDTH-1:0] acc_next;

    assign acc_hi = acc[2*WIDTH-1:WIDTH];
    assign acc_lo = acc[WIDTH-1:0];

    // Divide subtracts the divisor from the partial remainder shifted left by one.
    assign addend = div_mode ? {acc_hi, acc_lo[WIDTH-1]} : {1'b0, acc_hi};
    assign sum    = div_mode ? ({1'b0, addend} - {2'b00, operand})
                             : ({1'b0, addend} + {2'b00, operand});
    assign borrow = sum[WIDTH+1];

    always_comb begin
        acc_next = acc;
        if (div_mode) begin
            if (!borrow) begin
                acc_next = {sum[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {acc[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            if (acc_lo[0]) begin
                acc_next = {sum[WIDTH:0], acc_lo[WIDTH-1:1]};
            end else begin
                acc_next = {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
            end
        end
    end

    // op_a seeds the low half (multiplier or dividend); op_b is the fixed addend.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc     <= '0;
            operand <= '0;
        end else if (load) begin
            acc     <= {{WIDTH{1'b0}}, op_a};
            operand <= op_b;
        end else if (step) begin
            acc     <= acc_next;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative signed/unsigned multiply-divide unit with architectural HI/LO registers,
// flush, and a stall handshake for requests or HI/LO reads made while busy.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  mdu_op_t          op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hilo_rd,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    mdu_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic               div_mode;
    logic               neg_main;
    logic               neg_rem;
    logic               div_zero;

    logic               accept;
    logic               core_load;
    logic               core_step;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign busy  = (state != IDLE);
    assign stall = busy & (start | hilo_rd);

    assign accept    = (state == IDLE) && start && !flush && is_arith(op);
    assign core_load = accept;
    assign core_step = (state == CALC);

    assign abs_a = (is_signed(op) && src_a[WIDTH-1]) ? -src_a : src_a;
    assign abs_b = (is_signed(op) && src_b[WIDTH-1]) ? -src_b : src_b;

    mdu_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (core_load),
        .step     (core_step),
        .div_mode (div_mode),
        .op_a     (abs_a),
        .op_b     (abs_b),
        .acc      (acc)
    );

    assign quo = acc[WIDTH-1:0];
    assign rem = acc[2*WIDTH-1:WIDTH];

    // Divide by zero leaves |a| as remainder, so sign restoration gives back src_a.
    always_comb begin
        prod_fix = neg_main ? -acc : acc;
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        if (div_mode) begin
            fix_hi = neg_rem ? -rem : rem;
            fix_lo = div_zero ? {WIDTH{1'b1}} : (neg_main ? -quo : quo);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            div_mode <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (is_arith(op)) begin
                                state    <= CALC;
                                cnt      <= '0;
                                div_mode <= is_div(op);
                                neg_main <= is_signed(op) & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                                neg_rem  <= is_signed(op) & src_a[WIDTH-1];
                                div_zero <= (src_b == '0);
                            end else if (op == MDU_MTHI) begin
                                hi <= src_a;
                            end else if (op == MDU_MTLO) begin
                                lo <= src_a;
                            end
                        end
                    end
                    CALC: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            state <= FIXUP;
                        end
                    end
                    FIXUP: begin
                        hi    <= fix_hi;
                        lo    <= fix_lo;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed corner cases, stall/flush/reset
// scenarios and a randomized run checked against a behavioural reference model.
module tb_mul_div_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    mdu_op_t      op = MDU_MULT;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         hilo_rd = 1'b0;
    logic         flush = 1'b0;
    logic         busy;
    logic         stall;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    exp_t drv_e;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .hilo_rd (hilo_rd),
        .flush   (flush),
        .busy    (busy),
        .stall   (stall),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    // Free-running clock and a cycle counter used to time done against acceptance.
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Every done pulse must match the oldest outstanding result, at the right cycle.
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                checkOutput("result_hi", 64'(hi), 64'(mon_e.hi));
                checkOutput("result_lo", 64'(lo), 64'(mon_e.lo));
                checkOutput("latency", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    // Independent reference using native wide arithmetic.
    function automatic logic [63:0] model(input mdu_op_t m_op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        case (m_op)
            MDU_MULT: begin
                p = sa * sb;
                return p;
            end
            MDU_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                return p;
            end
            MDU_DIV: begin
                if (b == '0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == '0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 9))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return W'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    // Drives one MULT*/DIV* request, holding it through any stall, and records the
    // expected result and completion cycle once the request will be taken.
    task automatic applyStimulus(input mdu_op_t s_op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [W-1:0] e_hi,
                                 input logic [W-1:0] e_lo);
        int n;
        op    = s_op;
        src_a = a;
        src_b = b;
        start = 1'b1;
        #1;
        n = 0;
        while (stall && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) checkOutput("accept_timeout", 64'd1, 64'd0);
        drv_e.hi  = e_hi;
        drv_e.lo  = e_lo;
        drv_e.cyc = cyc + 1 + W + 1;
        sb_q.push_back(drv_e);
        @(posedge clk);
        #1;
        start = 1'b0;
        src_a = $urandom();
        src_b = $urandom();
    endtask

    task automatic mtWrite(input mdu_op_t s_op, input logic [W-1:0] a);
        op    = s_op;
        src_a = a;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((busy || sb_q.size() != 0) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) checkOutput("idle_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] r;
        mdu_op_t rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        start = 1'b1;
        op    = MDU_MULT;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_hi", 64'(hi), 64'd0);
        checkOutput("reset_lo", 64'(lo), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_stall", 64'(stall), 64'd0);
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed corner cases");
        applyStimulus(MDU_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        applyStimulus(MDU_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE);
        applyStimulus(MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        applyStimulus(MDU_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF);
        applyStimulus(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        applyStimulus(MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        applyStimulus(MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        waitIdle();

        $display("[TB] MTHI/MTLO");
        mtWrite(MDU_MTHI, 32'h1234_5678);
        checkOutput("mthi_hi", 64'(hi), 64'h1234_5678);
        mtWrite(MDU_MTLO, 32'h9ABC_DEF0);
        checkOutput("mtlo_lo", 64'(lo), 64'h9ABC_DEF0);
        checkOutput("mtlo_hi", 64'(hi), 64'h1234_5678);
        checkOutput("mt_busy", 64'(busy), 64'd0);
        checkOutput("mt_done", 64'(done), 64'd0);

        $display("[TB] stall while busy");
        applyStimulus(MDU_MULT, 32'h0000_1234, 32'h0000_0100, 32'h0000_0000, 32'h0012_3400);
        op      = MDU_DIVU;
        src_a   = 32'd100;
        src_b   = 32'd7;
        start   = 1'b1;
        hilo_rd = 1'b1;
        for (int i = 0; i < W + 1; i++) begin
            #1;
            checkOutput("stall_busy", 64'(stall), 64'd1);
            @(posedge clk);
            #1;
        end
        #1;
        checkOutput("stall_done_cycle", 64'(stall), 64'd0);
        checkOutput("done_cycle_done", 64'(done), 64'd1);
        drv_e.hi  = 32'd2;
        drv_e.lo  = 32'd14;
        drv_e.cyc = cyc + 1 + W + 1;
        sb_q.push_back(drv_e);
        @(posedge clk);
        #1;
        start   = 1'b0;
        hilo_rd = 1'b0;
        waitIdle();

        $display("[TB] flush and reset mid-operation");
        mtWrite(MDU_MTHI, 32'hA5A5_A5A5);
        mtWrite(MDU_MTLO, 32'hA5A5_A5A5);
        op    = MDU_DIV;
        src_a = 32'd100;
        src_b = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush_busy", 64'(busy), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        checkOutput("flush_hi", 64'(hi), 64'hA5A5_A5A5);
        checkOutput("flush_lo", 64'(lo), 64'hA5A5_A5A5);

        op    = MDU_DIV;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("rst_mid_hi", 64'(hi), 64'd0);
        checkOutput("rst_mid_lo", 64'(lo), 64'd0);
        checkOutput("rst_mid_busy", 64'(busy), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        checkOutput("rst_mid_idle", 64'(busy), 64'd0);

        op    = MDU_MTHI;
        src_a = 32'hDEAD_BEEF;
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("flush_mthi_hi", 64'(hi), 64'd0);
        op = MDU_MULT;
        @(posedge clk);
        #1;
        checkOutput("flush_start_busy", 64'(busy), 64'd0);
        start = 1'b0;
        flush = 1'b0;

        $display("[TB] randomized run");
        for (int k = 0; k < 1500; k++) begin
            rop = mdu_op_t'($urandom_range(0, 3));
            ra  = pick();
            rb  = pick();
            r   = model(rop, ra, rb);
            applyStimulus(rop, ra, rb, r[63:32], r[31:0]);
        end
        waitIdle();
        checkOutput("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
